// File: rtl/lc3_decode_stage_if.sv
// LC-3 decode stage bus bundle.
// Fetch-side inputs and execute-side outputs of the decode stage.
interface lc3_decode_stage_if;
  logic        en_decode;
  logic [15:0] instr_dout;
  logic [15:0] npc_in;
  logic [2:0]  Sr;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [2:0]  psr_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;
  logic        decode_valid;
  logic        illegal_op;

  modport master (
    output en_decode, instr_dout, npc_in, Sr,
    input  IR, npc_out, psr_out, E_Control,
    input  W_Control, Mem_Control,
    input  decode_valid, illegal_op
  );

  modport slave (
    input  en_decode, instr_dout, npc_in, Sr,
    output IR, npc_out, psr_out, E_Control,
    output W_Control, Mem_Control,
    output decode_valid, illegal_op
  );
endinterface

// File: rtl/lc3_decode_stage.sv
// LC-3 decode stage.
// Registers the fetched instruction and its execute/writeback/memory controls.
module lc3_decode_stage #(
  parameter logic [15:0] RESET_NPC = 16'h3000,
  parameter bit ILLEGAL_ZERO_CTRL = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en_decode,
  input  logic [15:0] instr_dout,
  input  logic [15:0] npc_in,
  input  logic [2:0]  Sr,
  output logic [15:0] IR,
  output logic [15:0] npc_out,
  output logic [2:0]  psr_out,
  output logic [5:0]  E_Control,
  output logic [1:0]  W_Control,
  output logic        Mem_Control,
  output logic        decode_valid,
  output logic        illegal_op
);

  logic [15:0] ir_q, ir_d;
  logic [15:0] npc_q, npc_d;
  logic [2:0]  psr_q, psr_d;
  logic [5:0]  e_q, e_d;
  logic [1:0]  w_q, w_d;
  logic        m_q, m_d;
  logic        vld_q, vld_d;
  logic        ill_q, ill_d;

  logic [5:0]  e_dec;
  logic [1:0]  w_dec;
  logic        m_dec;
  logic        ill_dec;
  logic        imm;

  assign imm = instr_dout[5];

  // Combinational decode of the incoming opcode.
  always_comb begin
    e_dec   = 6'b000000;
    w_dec   = 2'd0;
    m_dec   = 1'b0;
    ill_dec = 1'b0;
    case (instr_dout[15:12])
      4'b0001: e_dec = {5'b00000, ~imm};
      4'b0101: e_dec = {5'b01000, ~imm};
      4'b1001: e_dec = 6'b100000;
      4'b0000: e_dec = 6'b000110;
      4'b1100: e_dec = 6'b001100;
      4'b0010: begin
        e_dec = 6'b000110;
        w_dec = 2'd2;
      end
      4'b0110: begin
        e_dec = 6'b001000;
        w_dec = 2'd2;
      end
      4'b1010: begin
        e_dec = 6'b000110;
        w_dec = 2'd2;
        m_dec = 1'b1;
      end
      4'b1110: begin
        e_dec = 6'b000110;
        w_dec = 2'd1;
      end
      4'b0011: e_dec = 6'b000110;
      4'b0111: e_dec = 6'b001000;
      4'b1011: begin
        e_dec = 6'b000110;
        m_dec = 1'b1;
      end
      default: begin
        ill_dec = 1'b1;
        // ADD-imm encoding is all zeros as well
        e_dec   = ILLEGAL_ZERO_CTRL ? 6'b000000 : 6'b000000;
      end
    endcase
  end

  // Capture on enable; hold state and drop valid while stalled.
  always_comb begin
    ir_d  = ir_q;
    npc_d = npc_q;
    psr_d = psr_q;
    e_d   = e_q;
    w_d   = w_q;
    m_d   = m_q;
    ill_d = ill_q;
    vld_d = 1'b0;
    if (en_decode) begin
      ir_d  = instr_dout;
      npc_d = npc_in;
      psr_d = Sr;
      e_d   = e_dec;
      w_d   = w_dec;
      m_d   = m_dec;
      ill_d = ill_dec;
      vld_d = 1'b1;
    end
  end

  // Pipeline registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir_q  <= 16'h0000;
      npc_q <= RESET_NPC;
      psr_q <= 3'b000;
      e_q   <= 6'b000000;
      w_q   <= 2'd0;
      m_q   <= 1'b0;
      vld_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      ir_q  <= ir_d;
      npc_q <= npc_d;
      psr_q <= psr_d;
      e_q   <= e_d;
      w_q   <= w_d;
      m_q   <= m_d;
      vld_q <= vld_d;
      ill_q <= ill_d;
    end
  end

  assign IR           = ir_q;
  assign npc_out      = npc_q;
  assign psr_out      = psr_q;
  assign E_Control    = e_q;
  assign W_Control    = w_q;
  assign Mem_Control  = m_q;
  assign decode_valid = vld_q;
  assign illegal_op   = ill_q;

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Testbench for lc3_decode_stage.
// Scoreboard of expected decodes popped by a monitor on decode_valid.
module tb_lc3_decode_stage;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] npc;
    logic [2:0]  psr;
    logic [5:0]  e;
    logic [1:0]  w;
    logic        m;
    logic        ill;
  } exp_t;

  logic clock;
  logic reset;

  lc3_decode_stage_if bus ();

  lc3_decode_stage #(
    .RESET_NPC(16'h3000),
    .ILLEGAL_ZERO_CTRL(1'b1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .en_decode    (bus.en_decode),
    .instr_dout   (bus.instr_dout),
    .npc_in       (bus.npc_in),
    .Sr           (bus.Sr),
    .IR           (bus.IR),
    .npc_out      (bus.npc_out),
    .psr_out      (bus.psr_out),
    .E_Control    (bus.E_Control),
    .W_Control    (bus.W_Control),
    .Mem_Control  (bus.Mem_Control),
    .decode_valid (bus.decode_valid),
    .illegal_op   (bus.illegal_op)
  );

  int   vectors;
  int   miscompares;
  exp_t sb[$];
  exp_t held;
  exp_t rst_val;

  // Reference table indexed by opcode: {E, W, M, legal}.
  logic [5:0] tab_e[16];
  logic [1:0] tab_w[16];
  logic       tab_m[16];
  logic       tab_ok[16];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic set_op(input int op, input logic [5:0] e,
                        input logic [1:0] w, input logic m,
                        input logic ok);
    tab_e[op]  = e;
    tab_w[op]  = w;
    tab_m[op]  = m;
    tab_ok[op] = ok;
  endtask

  task automatic build_table();
    for (int i = 0; i < 16; i++) set_op(i, 6'd0, 2'd0, 1'b0, 1'b0);
    set_op(0,  6'b000110, 2'd0, 1'b0, 1'b1);
    set_op(1,  6'b000001, 2'd0, 1'b0, 1'b1);
    set_op(2,  6'b000110, 2'd2, 1'b0, 1'b1);
    set_op(3,  6'b000110, 2'd0, 1'b0, 1'b1);
    set_op(5,  6'b010001, 2'd0, 1'b0, 1'b1);
    set_op(6,  6'b001000, 2'd2, 1'b0, 1'b1);
    set_op(7,  6'b001000, 2'd0, 1'b0, 1'b1);
    set_op(9,  6'b100000, 2'd0, 1'b0, 1'b1);
    set_op(10, 6'b000110, 2'd2, 1'b1, 1'b1);
    set_op(11, 6'b000110, 2'd0, 1'b1, 1'b1);
    set_op(12, 6'b001100, 2'd0, 1'b0, 1'b1);
    set_op(14, 6'b000110, 2'd1, 1'b0, 1'b1);
  endtask

  function automatic exp_t model(input logic [15:0] ins,
                                 input logic [15:0] npc,
                                 input logic [2:0] sr);
    exp_t r;
    int op;
    op    = int'(ins[15:12]);
    r.ir  = ins;
    r.npc = npc;
    r.psr = sr;
    r.ill = !tab_ok[op];
    r.e   = tab_e[op];
    r.w   = tab_w[op];
    r.m   = tab_m[op];
    // Immediate form of ADD/AND clears op2select
    if ((op == 1 || op == 5) && ins[5]) r.e[0] = 1'b0;
    if (r.ill) begin
      r.e = 6'd0;
      r.w = 2'd0;
      r.m = 1'b0;
    end
    return r;
  endfunction

  function automatic exp_t snap();
    exp_t a;
    a.ir  = bus.IR;
    a.npc = bus.npc_out;
    a.psr = bus.psr_out;
    a.e   = bus.E_Control;
    a.w   = bus.W_Control;
    a.m   = bus.Mem_Control;
    a.ill = bus.illegal_op;
    return a;
  endfunction

  task automatic cmp(input string name, input exp_t x,
                     input logic vld_req);
    exp_t a;
    a = snap();
    vectors++;
    if (a != x || bus.decode_valid !== vld_req) begin
      miscompares++;
      $display("FAIL %s got ir=%h npc=%h psr=%0d e=%b w=%0d m=%b ill=%b v=%b want ir=%h npc=%h psr=%0d e=%b w=%0d m=%b ill=%b v=%b",
        name, a.ir, a.npc, a.psr, a.e, a.w, a.m, a.ill,
        bus.decode_valid, x.ir, x.npc, x.psr, x.e, x.w, x.m,
        x.ill, vld_req);
    end
  endtask

  // Monitor: each valid output pops the oldest expected decode.
  always @(posedge clock) begin
    #1;
    if (reset && bus.decode_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_underflow got valid=1 want empty=0");
      end else begin
        cmp("decode", sb.pop_front(), 1'b1);
      end
    end
  end

  task automatic issue(input logic [15:0] ins, input logic [15:0] npc,
                       input logic [2:0] sr);
    @(negedge clock);
    bus.en_decode  = 1'b1;
    bus.instr_dout = ins;
    bus.npc_in     = npc;
    bus.Sr         = sr;
    held = model(ins, npc, sr);
    sb.push_back(held);
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bus.en_decode  = 1'b0;
      bus.instr_dout = 16'($urandom);
      bus.npc_in     = 16'($urandom);
      bus.Sr         = 3'($urandom);
      @(posedge clock);
      #1;
      cmp("stall_hold", held, 1'b0);
    end
  endtask

  task automatic rand_inputs();
    bus.en_decode  = 1'($urandom);
    bus.instr_dout = 16'($urandom);
    bus.npc_in     = 16'($urandom);
    bus.Sr         = 3'($urandom);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    build_table();
    rst_val = '{ir: 16'h0, npc: 16'h3000, psr: 3'd0, e: 6'd0,
                w: 2'd0, m: 1'b0, ill: 1'b0};
    held = rst_val;

    reset = 1'b1;
    rand_inputs();
    #1 reset = 1'b0;
    #1 cmp("reset_async", rst_val, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      rand_inputs();
      cmp("reset_hold", rst_val, 1'b0);
    end
    @(negedge clock);
    bus.en_decode = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1 cmp("reset_release", rst_val, 1'b0);

    issue(16'h1283, 16'h3001, 3'b010);
    issue(16'h5A7F, 16'h3002, 3'b001);
    issue(16'hA5FF, 16'h3003, 3'b100);
    issue(16'hE1FE, 16'h3004, 3'b010);
    issue(16'h6A3F, 16'h3005, 3'b001);
    stall(3);
    issue(16'hF025, 16'h3006, 3'b010);
    stall(1);
    issue(16'h0E02, 16'h3007, 3'b100);
    issue(16'h1020, 16'h3008, 3'b001);
    issue(16'h8000, 16'h3009, 3'b010);
    issue(16'h4123, 16'h300A, 3'b010);
    issue(16'hD000, 16'h300B, 3'b010);
    issue(16'h903F, 16'h300C, 3'b001);
    issue(16'hC1C0, 16'h300D, 3'b100);
    issue(16'hB444, 16'h300E, 3'b100);
    issue(16'h7042, 16'h300F, 3'b100);
    issue(16'h3203, 16'h3010, 3'b001);
    issue(16'h2404, 16'h3011, 3'b001);
    stall(1);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3) == 0) stall(int'($urandom_range(2, 1)));
      else issue(16'($urandom), 16'($urandom), 3'($urandom));
    end
    stall(1);

    // Reset mid-stream between edges with enable high.
    @(negedge clock);
    bus.en_decode  = 1'b1;
    bus.instr_dout = 16'h1283;
    #2 reset = 1'b0;
    #1 cmp("reset_mid", rst_val, 1'b0);
    @(posedge clock);
    #1 cmp("reset_mid_edge", rst_val, 1'b0);
    @(negedge clock);
    bus.en_decode = 1'b0;
    reset = 1'b1;
    held = rst_val;
    @(posedge clock);
    #1 cmp("reset_mid_release", rst_val, 1'b0);
    issue(16'hE1FE, 16'h4001, 3'b010);
    issue(16'h5A60, 16'h4002, 3'b001);
    stall(2);

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain got %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lc3_decode_stage.md
Name: lc3_decode_stage

Overview:
Decode stage of the LC-3 pipeline. It consumes the fetched instruction (instr_dout), next PC (npc_in), status bits (Sr) and the decode enable from the fetch/memory side. It registers the instruction and derives the execute, writeback and memory control words consumed by the execute stage. All outputs are registered, with one-cycle latency from an enabled capture.

Parameters:
RESET_NPC, 16'h3000, npc_out value on reset.
ILLEGAL_ZERO_CTRL, 1, when 1 an illegal opcode forces all control words to zero.

Ports:
clock  input  1  pipeline clock, rising-edge active
reset  input  1  asynchronous, active-low reset (asserted when 0)
en_decode  input  1  capture enable; low = stage stalled, outputs hold
instr_dout  input  16  instruction word from instruction memory
npc_in  input  16  PC+1 from fetch
Sr  input  3  NZP status bits from writeback
IR  output  16  registered instruction
npc_out  output  16  registered npc_in
psr_out  output  3  registered Sr
E_Control  output  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
W_Control  output  2  writeback select: 0 ALU, 1 LEA/PC-relative, 2 memory
Mem_Control  output  1  1 = indirect access (LDI/STI)
decode_valid  output  1  registered outputs hold a newly decoded instruction
illegal_op  output  1  captured opcode unsupported

Behaviour:
- Reset (reset==0, asynchronous) sets outputs as follows, and they hold until the first enabled edge after release:
  - IR=0, npc_out=RESET_NPC, psr_out=0
  - E_Control=0, W_Control=0, Mem_Control=0
  - decode_valid=0, illegal_op=0
- Rising clock with en_decode=1 captures all inputs:
  - IR<=instr_dout, npc_out<=npc_in, psr_out<=Sr
  - Control outputs take the decode of instr_dout; decode_valid<=1.
- Rising clock with en_decode=0: IR, npc_out, psr_out and the control outputs hold; decode_valid<=0.
- Latency is one clock. Back-to-back enables give one decoded instruction per cycle with no bubbles.
- Decode is keyed on instr_dout[15:12]. Bit 5 is the immediate flag for ADD/AND. Encodings {alu,pcs1,pcs2,op2} / W / M:
  - ADD reg: 000001 / 0 / 0; ADD imm: 000000 / 0 / 0
  - AND reg: 010001 / 0 / 0; AND imm: 010000 / 0 / 0
  - NOT: 100000 / 0 / 0
  - BR: 000110 / 0 / 0
  - JMP: 001100 / 0 / 0
  - LD: 000110 / 2 / 0; LDR: 001000 / 2 / 0; LDI: 000110 / 2 / 1
  - LEA: 000110 / 1 / 0
  - ST: 000110 / 0 / 0; STR: 001000 / 0 / 0; STI: 000110 / 0 / 1
- Illegal opcodes are RTI 1000, JSR 0100, RES 1101 and TRAP 1111. On capture:
  - illegal_op<=1; IR and npc_out are still captured.
  - Controls are zero if ILLEGAL_ZERO_CTRL=1, else ADD-imm encoding.
  - illegal_op clears on the next enabled capture of a legal opcode and holds while stalled.
- Reset asserted mid-stream overrides any enable in the same cycle. Outputs go to reset values immediately, without waiting for a clock edge.
- X on instr_dout while en_decode=0 must not propagate to any output.

Test Plan:
- Hold reset=0 two cycles with random inputs -> npc_out=16'h3000; all other outputs 0 before and after the first clock.
- Release reset; en_decode=1, instr_dout=16'h1283 (ADD reg), npc_in=16'h3001, Sr=3'b010 -> next edge: IR=16'h1283, npc_out=16'h3001, psr_out=2, E_Control=6'b000001, W_Control=0, decode_valid=1.
- Back-to-back enabled 16'h5A7F (AND imm), 16'hA5FF (LDI), 16'hE1FE (LEA) -> E/W/M of 010000/0/0, then 000110/2/1, then 000110/1/0 on consecutive edges.
- Capture 16'h6A3F (LDR), then en_decode=0 for 3 cycles with instr_dout changing -> IR holds 16'h6A3F, E_Control=001000, W_Control=2, decode_valid=0 after the first stalled edge.
- Enabled 16'hF025 (TRAP) -> illegal_op=1, controls 0, IR=16'hF025. Next enabled 16'h0E02 (BR) -> illegal_op=0, E_Control=000110.
- Assert reset between clock edges while en_decode=1 streaming -> outputs return to reset values asynchronously. The first enabled edge after release decodes normally.
